// File: rtl/secret_box_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : secret_box_ctrl
//  Purpose  : Lock-sequencing controller for the secret box. Compares an
//             entered key against a stored password, counts wrong attempts,
//             holds fail / lockout delays, auto-relocks after a timeout and
//             allows the password to be changed while open.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      system clock
//    rst          in   1      asynchronous, active-high reset
//    key          in   KEY_W  key switch value
//    enter        in   1      single-cycle pulse from the debouncer
//    set_req      in   1      level; in OPEN, enter stores a new password
//    unlocked     out  1      high in OPEN
//    alarm        out  1      high in LOCKOUT
//    new_key_ack  out  1      one-cycle pulse when the password is updated
//    tries_left   out  2      remaining attempts, saturating at 3
//    r_led        out  1      high in FAIL or LOCKOUT
//    g_led        out  1      high in OPEN
//    b_led        out  1      high in LOCKED or CHECK
//    state_o      out  3      LOCKED=0 CHECK=1 OPEN=2 FAIL=3 LOCKOUT=4
// ============================================================================
module secret_box_ctrl #(
   parameter int unsigned            KEY_W       = 8,
   parameter logic [KEY_W-1:0]       DEFAULT_KEY = 8'hF0,
   parameter int unsigned            MAX_TRIES   = 3,
   parameter int unsigned            FAIL_CYCLES = 25_000_000,
   parameter int unsigned            LOCK_CYCLES = 250_000_000,
   parameter int unsigned            OPEN_CYCLES = 500_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key,
   input  logic             enter,
   input  logic             set_req,
   output logic             unlocked,
   output logic             alarm,
   output logic             new_key_ack,
   output logic [1:0]       tries_left,
   output logic             r_led,
   output logic             g_led,
   output logic             b_led,
   output logic [2:0]       state_o
);

   localparam int unsigned TW = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

   localparam logic [TW-1:0] c_MAX_TRIES = TW'(MAX_TRIES);
   localparam logic [TW-1:0] c_ONE_TRY   = TW'(1);
   localparam logic [31:0]   c_FAIL_LOAD = 32'(FAIL_CYCLES - 1);
   localparam logic [31:0]   c_LOCK_LOAD = 32'(LOCK_CYCLES - 1);
   localparam logic [31:0]   c_OPEN_LOAD = 32'(OPEN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_LOCKED  = 3'd0,
      S_CHECK   = 3'd1,
      S_OPEN    = 3'd2,
      S_FAIL    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      timer_q, timer_d;
   logic [TW-1:0]    tries_q, tries_d;
   logic [KEY_W-1:0] pwd_q, pwd_d;
   logic [KEY_W-1:0] key_snap_q, key_snap_d;
   logic             ack_q, ack_d;

   logic             w_timer_done;

   assign w_timer_done = (timer_q == 32'd0);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_LOCKED;
         timer_q    <= 32'd0;
         tries_q    <= c_MAX_TRIES;
         pwd_q      <= DEFAULT_KEY;
         key_snap_q <= '0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         tries_q    <= tries_d;
         pwd_q      <= pwd_d;
         key_snap_q <= key_snap_d;
         ack_q      <= ack_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. Timed states are entered with N-1 in the timer and
   // leave on the edge that sees zero, giving exactly N cycles of residence.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      tries_d    = tries_q;
      pwd_d      = pwd_q;
      key_snap_d = key_snap_q;
      ack_d      = 1'b0;

      case (state_q)
         S_LOCKED: begin
            timer_d = 32'd0;
            if (enter) begin
               key_snap_d = key;
               state_d    = S_CHECK;
            end
         end

         S_CHECK: begin
            if (key_snap_q == pwd_q) begin
               state_d = S_OPEN;
               tries_d = c_MAX_TRIES;
               timer_d = c_OPEN_LOAD;
            end else if (tries_q > c_ONE_TRY) begin
               state_d = S_FAIL;
               tries_d = tries_q - c_ONE_TRY;
               timer_d = c_FAIL_LOAD;
            end else begin
               state_d = S_LOCKOUT;
               tries_d = '0;
               timer_d = c_LOCK_LOAD;
            end
         end

         S_OPEN: begin
            // A user action on the expiry edge takes priority over relock.
            if (enter && set_req) begin
               pwd_d   = key;
               ack_d   = 1'b1;
               timer_d = c_OPEN_LOAD;
            end else if (enter || w_timer_done) begin
               state_d = S_LOCKED;
               timer_d = 32'd0;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end

         S_FAIL: begin
            if (w_timer_done) begin
               state_d = S_LOCKED;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end

         S_LOCKOUT: begin
            if (w_timer_done) begin
               state_d = S_LOCKED;
               tries_d = c_MAX_TRIES;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end

         default: begin
            state_d = S_LOCKED;
            timer_d = 32'd0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Moore output decode
   // -------------------------------------------------------------------------
   assign state_o     = state_q;
   assign unlocked    = (state_q == S_OPEN);
   assign g_led       = (state_q == S_OPEN);
   assign alarm       = (state_q == S_LOCKOUT);
   assign r_led       = (state_q == S_FAIL) || (state_q == S_LOCKOUT);
   assign b_led       = (state_q == S_LOCKED) || (state_q == S_CHECK);
   assign new_key_ack = ack_q;

   // tries_left saturates at 3; a 1-bit counter never needs the clamp.
   generate
      if (TW < 2) begin : g_tries_narrow
         assign tries_left = {1'b0, tries_q};
      end else begin : g_tries_wide
         assign tries_left = (tries_q > TW'(3)) ? 2'd3 : tries_q[1:0];
      end
   endgenerate

endmodule
`default_nettype wire
